// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that shares one registered W-bit adder between N requesters.
// Results return on a single response channel tagged with the requester ID.
module adder_rr_scheduler #(
   parameter int N    = 4,
   parameter int W    = 32,
   parameter int ID_W = 2
) (
   input  logic            okClk,
   input  logic            rst_n,
   input  logic [N-1:0]    enable_mask,
   input  logic [N-1:0]    req_valid,
   input  logic [N*W-1:0]  req_a,
   input  logic [N*W-1:0]  req_b,
   output logic [N-1:0]    req_ready,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [ID_W-1:0] resp_id,
   output logic [W-1:0]    resp_sum,
   output logic            resp_carry,
   output logic            busy,
   output logic [15:0]     op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant_id;
   logic [ID_W-1:0] grant_sel;
   logic            grant_found;
   logic [N-1:0]    elig;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [W-1:0]    a_sel;
   logic [W-1:0]    b_sel;
   logic [ID_W:0]   sum_idx;
   logic [ID_W-1:0] idx;

   assign elig = req_valid & enable_mask;

   // Search starts one past the last served requester, so the last winner is tried last.
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = '0;
      sum_idx     = '0;
      idx         = '0;
      for (int k = 1; k <= N; k++) begin
         sum_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum_idx >= (ID_W+1)'(N))
            sum_idx = sum_idx - (ID_W+1)'(N);
         idx = sum_idx[ID_W-1:0];
         if (!grant_found && elig[idx]) begin
            grant_found = 1'b1;
            grant_sel   = idx;
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (ID_W'(i) == grant_sel) begin
            a_sel = req_a[i*W +: W];
            b_sel = req_b[i*W +: W];
         end
      end
   end

   // Gated by rst_n so the accept pulse vanishes the instant reset is asserted.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && grant_found)
         req_ready[grant_sel] = 1'b1;
   end

   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= ID_W'(N-1);
         grant_id   <= '0;
         op_a       <= '0;
         op_b       <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_sum   <= '0;
         resp_carry <= 1'b0;
         busy       <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  op_a     <= a_sel;
                  op_b     <= b_sel;
                  grant_id <= grant_sel;
                  busy     <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               {resp_carry, resp_sum} <= {1'b0, op_a} + {1'b0, op_b};
               resp_id    <= grant_id;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_valid && resp_ready) begin
                  resp_valid <= 1'b0;
                  rr_ptr     <= resp_id;
                  op_count   <= op_count + 16'd1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: reset, round-robin order, overflow,
// masking, backpressure and mid-transaction reset, with hand-computed expectations.
module tb_adder_rr_scheduler;

   localparam int N    = 4;
   localparam int W    = 32;
   localparam int ID_W = 2;

   localparam logic [31:0] OP_A [4] = '{32'h11111111, 32'h22222222, 32'h80000000, 32'hFFFFFFF0};
   localparam logic [31:0] OP_B [4] = '{32'h00000001, 32'h11111111, 32'h80000000, 32'h00000020};
   localparam logic [31:0] EXP_SUM [4] = '{32'h11111112, 32'h33333333, 32'h00000000, 32'h00000010};
   localparam logic [3:0]  EXP_CARRY = 4'b1100;

   logic            okClk;
   logic            rst_n;
   logic [N-1:0]    enable_mask;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N-1:0]    req_ready;
   logic            resp_valid;
   logic            resp_ready;
   logic [ID_W-1:0] resp_id;
   logic [W-1:0]    resp_sum;
   logic            resp_carry;
   logic            busy;
   logic [15:0]     op_count;

   int vectors;
   int miscompares;

   adder_rr_scheduler #(.N(N), .W(W), .ID_W(ID_W)) dut (
      .okClk      (okClk),
      .rst_n      (rst_n),
      .enable_mask(enable_mask),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_carry (resp_carry),
      .busy       (busy),
      .op_count   (op_count)
   );

   initial begin
      okClk = 1'b0;
      forever #5 okClk = ~okClk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] valid,
                                input logic rready);
      enable_mask = mask;
      req_valid   = valid;
      resp_ready  = rready;
   endtask

   task automatic setOps(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge okClk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus('0, '0, 1'b0);
      step();
      @(negedge okClk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      int id;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      req_a       = '0;
      req_b       = '0;
      applyStimulus('0, '0, 1'b0);

      // 1. reset values, then one transaction on requester 2
      $display("[TB] test 1: reset and single transaction");
      #12;
      checkOutput("rst_req_ready",  32'(req_ready),  32'h0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_busy",       32'(busy),       32'h0);
      checkOutput("rst_resp_id",    32'(resp_id),    32'h0);
      checkOutput("rst_resp_sum",   resp_sum,        32'h0);
      checkOutput("rst_resp_carry", 32'(resp_carry), 32'h0);
      checkOutput("rst_op_count",   32'(op_count),   32'h0);
      @(negedge okClk);
      rst_n = 1'b1;
      #1;
      setOps(2, 32'd5, 32'd7);
      applyStimulus(4'hF, 4'b0100, 1'b0);
      #1;
      checkOutput("t1_req_ready", 32'(req_ready), 32'h4);
      step();
      checkOutput("t1_exec_busy",  32'(busy),      32'h1);
      checkOutput("t1_exec_ready", 32'(req_ready), 32'h0);
      applyStimulus(4'hF, 4'b0000, 1'b1);
      step();
      checkOutput("t1_resp_valid", 32'(resp_valid), 32'h1);
      checkOutput("t1_resp_id",    32'(resp_id),    32'h2);
      checkOutput("t1_resp_sum",   resp_sum,        32'd12);
      checkOutput("t1_resp_carry", 32'(resp_carry), 32'h0);
      step();
      checkOutput("t1_valid_drop", 32'(resp_valid), 32'h0);
      checkOutput("t1_op_count",   32'(op_count),   32'h1);
      checkOutput("t1_idle_busy",  32'(busy),       32'h0);

      // 2. all requesters valid, resp_ready high: grants 0,1,2,3,0,1,2,3 at 3 cycles each
      $display("[TB] test 2: round-robin with all requesters valid");
      doReset();
      for (int i = 0; i < 4; i++) setOps(i, OP_A[i], OP_B[i]);
      applyStimulus(4'hF, 4'hF, 1'b1);
      #1;
      for (int t = 0; t < 8; t++) begin
         id = t % 4;
         checkOutput("t2_grant", 32'(req_ready), 32'(1) << id);
         step();
         checkOutput("t2_exec_ready", 32'(req_ready), 32'h0);
         step();
         checkOutput("t2_resp_valid", 32'(resp_valid), 32'h1);
         checkOutput("t2_resp_id",    32'(resp_id),    32'(id));
         checkOutput("t2_resp_sum",   resp_sum,        EXP_SUM[id]);
         checkOutput("t2_resp_carry", 32'(resp_carry), 32'(EXP_CARRY[id]));
         step();
      end
      checkOutput("t2_op_count", 32'(op_count), 32'd8);

      // 3. carry out on requester 1, then a lone requester equal to rr_ptr
      $display("[TB] test 3: overflow and wrap-around search");
      setOps(1, 32'hFFFFFFFF, 32'h00000002);
      applyStimulus(4'hF, 4'b0010, 1'b1);
      #1;
      checkOutput("t3_grant", 32'(req_ready), 32'h2);
      step();
      step();
      checkOutput("t3_resp_id",    32'(resp_id),    32'h1);
      checkOutput("t3_resp_sum",   resp_sum,        32'h00000001);
      checkOutput("t3_resp_carry", 32'(resp_carry), 32'h1);
      step();
      setOps(1, 32'hFFFFFFFF, 32'h00000001);
      #1;
      checkOutput("t3_wrap_grant", 32'(req_ready), 32'h2);
      step();
      step();
      checkOutput("t3_ovf_id",    32'(resp_id),    32'h1);
      checkOutput("t3_ovf_sum",   resp_sum,        32'h00000000);
      checkOutput("t3_ovf_carry", 32'(resp_carry), 32'h1);
      step();
      checkOutput("t3_op_count", 32'(op_count), 32'd10);

      // 4. mask 1010: grants 1,3,1,3,1; mask cleared during the last RESP
      $display("[TB] test 4: enable mask");
      doReset();
      setOps(1, OP_A[1], OP_B[1]);
      applyStimulus(4'b1010, 4'hF, 1'b1);
      #1;
      for (int t = 0; t < 5; t++) begin
         id = (t % 2 == 0) ? 1 : 3;
         checkOutput("t4_grant", 32'(req_ready), 32'(1) << id);
         step();
         step();
         if (t == 4) applyStimulus(4'b0000, 4'hF, 1'b1);
         checkOutput("t4_resp_id",  32'(resp_id), 32'(id));
         checkOutput("t4_resp_sum", resp_sum,     EXP_SUM[id]);
         step();
      end
      for (int c = 0; c < 3; c++) begin
         checkOutput("t4_idle_ready", 32'(req_ready), 32'h0);
         checkOutput("t4_idle_busy",  32'(busy),      32'h0);
         step();
      end
      checkOutput("t4_op_count", 32'(op_count), 32'd5);

      // 5. backpressure: response held for 10 cycles, then the next grant right after
      $display("[TB] test 5: backpressure");
      applyStimulus(4'hF, 4'hF, 1'b0);
      #1;
      checkOutput("t5_grant", 32'(req_ready), 32'h4);
      step();
      step();
      for (int c = 0; c < 10; c++) begin
         if (c == 5) applyStimulus(4'h0, 4'h0, 1'b0);
         if (c == 8) applyStimulus(4'hF, 4'hF, 1'b0);
         #1;
         checkOutput("t5_hold_valid", 32'(resp_valid), 32'h1);
         checkOutput("t5_hold_sum",   resp_sum,        32'h00000000);
         checkOutput("t5_hold_id",    32'(resp_id),    32'h2);
         checkOutput("t5_hold_ready", 32'(req_ready),  32'h0);
         step();
      end
      applyStimulus(4'hF, 4'hF, 1'b1);
      step();
      checkOutput("t5_next_grant", 32'(req_ready),  32'h8);
      checkOutput("t5_op_count",   32'(op_count),   32'd6);
      checkOutput("t5_valid_drop", 32'(resp_valid), 32'h0);

      // 6. reset asserted during EXEC discards the transaction
      $display("[TB] test 6: reset mid-transaction");
      step();
      checkOutput("t6_exec_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_busy",   32'(busy),       32'h0);
      checkOutput("t6_rst_valid",  32'(resp_valid), 32'h0);
      checkOutput("t6_rst_ready",  32'(req_ready),  32'h0);
      checkOutput("t6_rst_count",  32'(op_count),   32'h0);
      checkOutput("t6_rst_id",     32'(resp_id),    32'h0);
      checkOutput("t6_rst_carry",  32'(resp_carry), 32'h0);
      applyStimulus(4'hF, 4'h0, 1'b1);
      step();
      step();
      @(negedge okClk);
      rst_n = 1'b1;
      #1;
      for (int c = 0; c < 4; c++) begin
         step();
         checkOutput("t6_post_valid", 32'(resp_valid), 32'h0);
         checkOutput("t6_post_busy",  32'(busy),       32'h0);
         checkOutput("t6_post_count", 32'(op_count),   32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
